// File: rtl/bomb_manager.sv
// bomb_manager: bomb slot controller for the bomberman datapath.
// Arms bombs on player drops, times fuse/flame, mirrors slots to object RAM.
module bomb_manager #(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_BOMBS    = 4,
  parameter int OBJ_BASE     = 3,
  parameter int FUSE_FRAMES  = 120,
  parameter int FLAME_FRAMES = 30
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     iVS,
  input  logic [NUM_PLAYERS-1:0]   iDrop,
  input  logic [9*NUM_PLAYERS-1:0] iPos,
  output logic [3:0]               oObjRam_addr,
  output logic [12:0]              oObjRam_data,
  output logic                     oObjRam_we,
  output logic [NUM_BOMBS-1:0]     oExplode,
  output logic                     oFull
);

  localparam int TMAX =
    (FUSE_FRAMES > FLAME_FRAMES) ? FUSE_FRAMES : FLAME_FRAMES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int IW = $clog2(NUM_BOMBS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_FLAME
  } slot_e;

  typedef enum logic {
    W_IDLE,
    W_WRITE
  } wr_e;

  logic                   last_vs;
  logic                   frame_syn;
  logic [7:0]             cnt;
  logic                   upd;
  logic [NUM_PLAYERS-1:0] pending;

  slot_e                  st   [NUM_BOMBS];
  slot_e                  st_n [NUM_BOMBS];
  logic [TW-1:0]          tm   [NUM_BOMBS];
  logic [TW-1:0]          tm_n [NUM_BOMBS];
  logic [4:0]             sx   [NUM_BOMBS];
  logic [4:0]             sx_n [NUM_BOMBS];
  logic [3:0]             sy   [NUM_BOMBS];
  logic [3:0]             sy_n [NUM_BOMBS];
  logic [NUM_BOMBS-1:0]   expl_n;
  logic                   full_n;
  logic                   hit;
  logic                   done;
  logic [4:0]             px;
  logic [3:0]             py;

  wr_e                    wst;
  wr_e                    wst_n;
  logic [IW-1:0]          idx;
  logic [IW-1:0]          idx_n;
  logic                   we_n;
  logic [3:0]             addr_n;
  logic [12:0]            data_n;
  logic [12:0]            slot_data;

  assign frame_syn = last_vs & ~iVS;
  assign upd       = (cnt == 8'd1);

  // Frame tick detection and saturating in-frame cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_vs <= 1'b0;
      cnt     <= '0;
    end else begin
      last_vs <= iVS;
      if (frame_syn)
        cnt <= '0;
      else if (cnt != 8'hFF)
        cnt <= cnt + 8'd1;
    end
  end

  // Next slot state: age timers, then allocate pending drops in player order.
  always_comb begin
    st_n   = st;
    tm_n   = tm;
    sx_n   = sx;
    sy_n   = sy;
    expl_n = '0;
    full_n = 1'b1;
    hit    = 1'b0;
    done   = 1'b0;
    px     = '0;
    py     = '0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      case (st[i])
        S_ARMED: begin
          if (tm[i] == TW'(1)) begin
            st_n[i]   = S_FLAME;
            tm_n[i]   = TW'(FLAME_FRAMES);
            expl_n[i] = 1'b1;
          end else begin
            tm_n[i] = tm[i] - TW'(1);
          end
        end
        S_FLAME: begin
          if (tm[i] == TW'(1)) begin
            st_n[i] = S_IDLE;
            tm_n[i] = '0;
          end else begin
            tm_n[i] = tm[i] - TW'(1);
          end
        end
        default: ;
      endcase
    end
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (pending[p]) begin
        px   = iPos[9*p+4 +: 5];
        py   = iPos[9*p +: 4];
        hit  = 1'b0;
        done = 1'b0;
        for (int i = 0; i < NUM_BOMBS; i++) begin
          if (st_n[i] != S_IDLE &&
              sx_n[i] == px && sy_n[i] == py)
            hit = 1'b1;
        end
        for (int i = 0; i < NUM_BOMBS; i++) begin
          if (!hit && !done && st_n[i] == S_IDLE) begin
            st_n[i] = S_ARMED;
            tm_n[i] = TW'(FUSE_FRAMES);
            sx_n[i] = px;
            sy_n[i] = py;
            done    = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (st_n[i] == S_IDLE)
        full_n = 1'b0;
    end
  end

  // Slot registers, sticky drop requests and status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BOMBS; i++) begin
        st[i] <= S_IDLE;
        tm[i] <= '0;
        sx[i] <= '0;
        sy[i] <= '0;
      end
      pending  <= '0;
      oExplode <= '0;
      oFull    <= 1'b0;
    end else begin
      pending  <= (upd ? '0 : pending) | iDrop;
      oExplode <= upd ? expl_n : '0;
      if (upd) begin
        for (int i = 0; i < NUM_BOMBS; i++) begin
          st[i] <= st_n[i];
          tm[i] <= tm_n[i];
          sx[i] <= sx_n[i];
          sy[i] <= sy_n[i];
        end
        oFull <= full_n;
      end
    end
  end

  // Object entry for the slot currently addressed by the writer.
  always_comb begin
    slot_data = '0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (idx == IW'(i)) begin
        case (st[i])
          S_ARMED: slot_data = {1'b1, 3'd2, sx[i], sy[i]};
          S_FLAME: slot_data = {1'b1, 3'd3, sx[i], sy[i]};
          default: slot_data = '0;
        endcase
      end
    end
  end

  // Writer next state: one burst of NUM_BOMBS writes per frame.
  always_comb begin
    wst_n  = wst;
    idx_n  = idx;
    we_n   = 1'b0;
    addr_n = oObjRam_addr;
    data_n = oObjRam_data;
    unique case (wst)
      W_IDLE: begin
        if (cnt == 8'd16) begin
          wst_n = W_WRITE;
          idx_n = '0;
        end
      end
      W_WRITE: begin
        if (idx == IW'(NUM_BOMBS)) begin
          wst_n = W_IDLE;
        end else begin
          we_n   = 1'b1;
          addr_n = 4'(OBJ_BASE) + 4'(idx);
          data_n = slot_data;
          idx_n  = idx + IW'(1);
        end
      end
    endcase
  end

  // Writer state and registered RAM port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wst          <= W_IDLE;
      idx          <= '0;
      oObjRam_we   <= 1'b0;
      oObjRam_addr <= '0;
      oObjRam_data <= '0;
    end else begin
      wst          <= wst_n;
      idx          <= idx_n;
      oObjRam_we   <= we_n;
      oObjRam_addr <= addr_n;
      oObjRam_data <= data_n;
    end
  end

endmodule

// File: tb/tb_bomb_manager.sv
// tb_bomb_manager: frame-level directed vectors for bomb_manager.
// Short fuse/flame so full bomb lifetimes fit in a few frames.
module tb_bomb_manager;

  localparam int FLEN = 30;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        iVS = 1'b0;
  logic [1:0]  iDrop = '0;
  logic [17:0] iPos = '0;
  logic [3:0]  oObjRam_addr;
  logic [12:0] oObjRam_data;
  logic        oObjRam_we;
  logic [3:0]  oExplode;
  logic        oFull;

  int total = 0;
  int bad = 0;

  int          wcnt [16] = '{default: 0};
  logic [12:0] wdat [16] = '{default: '0};
  int          ecyc = 0;
  logic [3:0]  elast = '0;

  typedef struct {
    logic [1:0]  drop;
    logic [17:0] pos;
    logic [12:0] d0;
    logic [12:0] d1;
    logic [12:0] d2;
    logic [12:0] d3;
    logic [3:0]  expl;
    logic        full;
  } vec_t;

  vec_t vt [17];

  bomb_manager #(
    .NUM_PLAYERS (2),
    .NUM_BOMBS   (4),
    .OBJ_BASE    (3),
    .FUSE_FRAMES (4),
    .FLAME_FRAMES(2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .iVS         (iVS),
    .iDrop       (iDrop),
    .iPos        (iPos),
    .oObjRam_addr(oObjRam_addr),
    .oObjRam_data(oObjRam_data),
    .oObjRam_we  (oObjRam_we),
    .oExplode    (oExplode),
    .oFull       (oFull)
  );

  always #5 clk = ~clk;

  // Record RAM writes and explode pulses away from the active edge.
  always @(negedge clk) begin
    if (oObjRam_we) begin
      wcnt[oObjRam_addr] = wcnt[oObjRam_addr] + 1;
      wdat[oObjRam_addr] = oObjRam_data;
    end
    if (oExplode != '0) begin
      ecyc  = ecyc + 1;
      elast = oExplode;
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] pp(input int x1, input int y1,
                                     input int x0, input int y0);
    return {5'(x1), 4'(y1), 5'(x0), 4'(y0)};
  endfunction

  task automatic frame(input logic [1:0] d, input logic [17:0] pos);
    @(negedge clk);
    iPos  = pos;
    iDrop = d;
    @(negedge clk);
    iDrop = '0;
    iVS   = 1'b1;
    @(negedge clk);
    iVS   = 1'b0;
    repeat (FLEN) @(negedge clk);
  endtask

  task automatic run_vec(input int f, input vec_t v);
    int          c0 [4];
    int          e0;
    logic [12:0] de [4];
    logic [3:0]  ea;
    for (int i = 0; i < 4; i++) c0[i] = wcnt[3+i];
    e0 = ecyc;
    frame(v.drop, v.pos);
    de[0] = v.d0;
    de[1] = v.d1;
    de[2] = v.d2;
    de[3] = v.d3;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("f%0d_nwr%0d", f, i), wcnt[3+i] - c0[i], 1);
      chk($sformatf("f%0d_data%0d", f, i), wdat[3+i], de[i]);
    end
    ea = (ecyc == e0) ? 4'd0 : elast;
    chk($sformatf("f%0d_expl", f), ea, v.expl);
    chk($sformatf("f%0d_ecyc", f), ecyc - e0, (v.expl != 0) ? 1 : 0);
    chk($sformatf("f%0d_full", f), oFull, v.full);
  endtask

  initial begin
    int seen;
    vt[0]  = '{2'b00, 18'd0,        13'h0,    13'h0,    13'h0,    13'h0,    4'h0, 1'b0};
    vt[1]  = '{2'b01, pp(0,0,3,5),  13'h1435, 13'h0,    13'h0,    13'h0,    4'h0, 1'b0};
    vt[2]  = '{2'b00, pp(0,0,3,5),  13'h1435, 13'h0,    13'h0,    13'h0,    4'h0, 1'b0};
    vt[3]  = '{2'b00, pp(0,0,3,5),  13'h1435, 13'h0,    13'h0,    13'h0,    4'h0, 1'b0};
    vt[4]  = '{2'b00, pp(0,0,3,5),  13'h1435, 13'h0,    13'h0,    13'h0,    4'h0, 1'b0};
    vt[5]  = '{2'b00, pp(0,0,3,5),  13'h1635, 13'h0,    13'h0,    13'h0,    4'h1, 1'b0};
    vt[6]  = '{2'b00, pp(0,0,3,5),  13'h1635, 13'h0,    13'h0,    13'h0,    4'h0, 1'b0};
    vt[7]  = '{2'b00, pp(0,0,3,5),  13'h0,    13'h0,    13'h0,    13'h0,    4'h0, 1'b0};
    vt[8]  = '{2'b11, pp(3,5,3,5),  13'h1435, 13'h0,    13'h0,    13'h0,    4'h0, 1'b0};
    vt[9]  = '{2'b10, pp(1,1,0,0),  13'h1435, 13'h1411, 13'h0,    13'h0,    4'h0, 1'b0};
    vt[10] = '{2'b01, pp(0,0,2,2),  13'h1435, 13'h1411, 13'h1422, 13'h0,    4'h0, 1'b0};
    vt[11] = '{2'b10, pp(4,4,0,0),  13'h1435, 13'h1411, 13'h1422, 13'h1444, 4'h0, 1'b1};
    vt[12] = '{2'b01, pp(0,0,7,7),  13'h1635, 13'h1411, 13'h1422, 13'h1444, 4'h1, 1'b1};
    vt[13] = '{2'b00, pp(0,0,7,7),  13'h1635, 13'h1611, 13'h1422, 13'h1444, 4'h2, 1'b1};
    vt[14] = '{2'b01, pp(0,0,1,1),  13'h0,    13'h1611, 13'h1622, 13'h1444, 4'h4, 1'b0};
    vt[15] = '{2'b01, pp(0,0,1,1),  13'h1411, 13'h0,    13'h1622, 13'h1644, 4'h8, 1'b0};
    vt[16] = '{2'b00, pp(0,0,1,1),  13'h1411, 13'h0,    13'h0,    13'h1644, 4'h0, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_we", oObjRam_we, 0);
    chk("rst_addr", oObjRam_addr, 0);
    chk("rst_data", oObjRam_data, 0);
    chk("rst_expl", oExplode, 0);
    chk("rst_full", oFull, 0);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);

    for (int f = 0; f < 17; f++) run_vec(f, vt[f]);

    // Reset in the middle of a write burst.
    @(negedge clk);
    iVS = 1'b1;
    @(negedge clk);
    iVS  = 1'b0;
    seen = 0;
    for (int c = 0; c < 60 && seen < 3; c++) begin
      @(negedge clk);
      if (oObjRam_we) seen++;
    end
    chk("burst_reach3", seen, 3);
    reset_n = 1'b0;
    #1;
    chk("midrst_we", oObjRam_we, 0);
    chk("midrst_addr", oObjRam_addr, 0);
    chk("midrst_data", oObjRam_data, 0);
    chk("midrst_full", oFull, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    run_vec(17, vt[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
